// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for muldiv_sequencer: FSM states, op fields, ALU function codes
// and a conditional-negate helper used by the optional signed path.
package muldiv_sequencer_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PREP = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  localparam logic [4:0] LAST_ITER = 5'd31;

  // op[0] selects DIV over MUL; op[1] requests a signed operation.
  localparam int OP_DIV_BIT = 0;
  localparam int OP_SGN_BIT = 1;

  typedef logic [5:0] alu_funct_t;

  localparam alu_funct_t ALU_ADDU = 6'b100001;
  localparam alu_funct_t ALU_SUBU = 6'b100011;
  localparam alu_funct_t ALU_AND  = 6'b100100;
  localparam alu_funct_t ALU_OR   = 6'b100101;
  localparam alu_funct_t ALU_XOR  = 6'b100110;
  localparam alu_funct_t ALU_SLTU = 6'b101011;

  function automatic logic [MD_WIDTH-1:0] cond_neg(input logic neg,
                                                   input logic [MD_WIDTH-1:0] v);
    return neg ? ('0 - v) : v;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Control-unit <-> muldiv_sequencer bus: start/busy/done handshake, MTHI/MTLO writes, HI/LO.
interface muldiv_sequencer_if #(
  parameter int WIDTH = muldiv_sequencer_pkg::MD_WIDTH
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data, wr_hi, wr_lo, wr_data,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, wr_hi, wr_lo, wr_data,
    output busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/muldiv_sequencer_alu.sv
// Private copy of the datapath ALU; the sequencer only drives ALU_ADDU and ALU_SUBU.
module muldiv_sequencer_alu
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_funct_t       funct,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    // NOTE: default assignment first so no funct value leaves y unassigned (no latch).
    y = '0;
    case (funct)
      ALU_ADDU: y = a + b;
      ALU_SUBU: y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SLTU: y = {{(WIDTH-1){1'b0}}, a < b};
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULTU/DIVU unit with architectural HI/LO (shift-add multiply, restoring divide).
// Define MULDIV_SIGNED_EN to add MULT/DIV via operand magnitudes and a result sign fixup.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  muldiv_sequencer_if.slave bus
);

  logic [1:0]       state;
  logic [4:0]       cnt;
  logic             accept;
  logic             op_div;
  alu_funct_t       funct_r;
  logic [WIDTH-1:0] rs_r;
  logic [WIDTH-1:0] rt_r;
  logic             rt_zero;

  // wh/wl hold {acc, lo_w} for MUL and {rem, quo} for DIV; opnd_b is mcand or divisor.
  logic [WIDTH-1:0] wh;
  logic [WIDTH-1:0] wl;
  logic [WIDTH-1:0] opnd_b;

  logic [WIDTH-1:0] prep_a;
  logic [WIDTH-1:0] prep_b;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;
  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] run_wh;
  logic [WIDTH-1:0] run_wl;
  logic             mul_carry;
  logic             div_take;

  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             done_r;
  logic             div_zero_r;

  assign accept  = (state == ST_IDLE) && bus.start;
  assign rt_zero = (rt_r == '0);

  assign bus.busy     = (state != ST_IDLE);
  assign bus.done     = done_r;
  assign bus.div_zero = div_zero_r;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;

  assign rem_sh = {wh[WIDTH-2:0], wl[WIDTH-1]};
  assign alu_a  = op_div ? rem_sh : wh;

  muldiv_sequencer_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a     (alu_a),
    .b     (opnd_b),
    .funct (funct_r),
    .y     (alu_y)
  );

  // One iteration: add-then-shift-right for MUL, shift-left-then-trial-subtract for DIV.
  always_comb begin
    run_wh    = wh;
    run_wl    = wl;
    mul_carry = 1'b0;
    div_take  = 1'b0;
    if (op_div) begin
      div_take = wh[WIDTH-1] | (rem_sh >= opnd_b);
      run_wh   = div_take ? alu_y : rem_sh;
      run_wl   = {wl[WIDTH-2:0], div_take};
    end else if (wl[0]) begin
      mul_carry = (alu_y < wh);
      run_wh    = {mul_carry, alu_y[WIDTH-1:1]};
      run_wl    = {alu_y[0], wl[WIDTH-1:1]};
    end else begin
      run_wh    = {1'b0, wh[WIDTH-1:1]};
      run_wl    = {wh[0], wl[WIDTH-1:1]};
    end
  end

`ifdef MULDIV_SIGNED_EN
  logic               op_sgn;
  logic               rs_neg;
  logic               rt_neg;
  logic [2*WIDTH-1:0] prod_neg;

  assign rs_neg   = op_sgn & rs_r[WIDTH-1];
  assign rt_neg   = op_sgn & rt_r[WIDTH-1];
  assign prep_a   = cond_neg(rs_neg, rs_r);
  assign prep_b   = cond_neg(rt_neg, rt_r);
  assign prod_neg = '0 - {wh, wl};

  // Quotient takes sign(rs)^sign(rt); remainder follows the dividend.
  always_comb begin
    fix_hi = wh;
    fix_lo = wl;
    if (!op_div) begin
      if (rs_neg ^ rt_neg) begin
        {fix_hi, fix_lo} = prod_neg;
      end
    end else begin
      fix_lo = cond_neg(rs_neg ^ rt_neg, wl);
      fix_hi = cond_neg(rs_neg, wh);
    end
  end
`else
  logic unused_op_sgn;

  assign unused_op_sgn = bus.op[OP_SGN_BIT];
  assign prep_a        = rs_r;
  assign prep_b        = rt_r;
  assign fix_hi        = wh;
  assign fix_lo        = wl;
`endif

  // NOTE: working registers carry no reset; the FSM loads them in PREP before any use.
  always_ff @(posedge clk) begin
    if (accept) begin
      rs_r   <= bus.rs_data;
      rt_r   <= bus.rt_data;
      op_div <= bus.op[OP_DIV_BIT];
`ifdef MULDIV_SIGNED_EN
      op_sgn <= bus.op[OP_SGN_BIT];
`endif
    end
    case (state)
      ST_PREP: begin
        wh      <= '0;
        wl      <= op_div ? prep_a : prep_b;
        opnd_b  <= op_div ? prep_b : prep_a;
        funct_r <= op_div ? ALU_SUBU : ALU_ADDU;
      end
      ST_RUN: begin
        wh <= run_wh;
        wl <= run_wl;
      end
      default: ;
    endcase
  end

  // NOTE: non-blocking assignments so every flop in this block samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      hi_r       <= '0;
      lo_r       <= '0;
    end else begin
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A start in the same cycle as MTHI/MTLO wins; the write is dropped.
          if (bus.start) begin
            state <= ST_PREP;
          end else begin
            if (bus.wr_hi) hi_r <= bus.wr_data;
            if (bus.wr_lo) lo_r <= bus.wr_data;
          end
        end
        ST_PREP: begin
          cnt   <= '0;
          state <= ST_RUN;
        end
        ST_RUN: begin
          cnt <= cnt + 5'd1;
          if (cnt == LAST_ITER) state <= ST_FIX;
        end
        ST_FIX: begin
          state  <= ST_IDLE;
          done_r <= 1'b1;
          if (op_div && rt_zero) begin
            hi_r       <= rs_r;
            lo_r       <= '1;
            div_zero_r <= 1'b1;
          end else begin
            hi_r <= fix_hi;
            lo_r <= fix_lo;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
